// File: rtl/axi4_write_arbiter_pkg.sv
// Shared types for the AXI4 write-channel arbiter: AW payload struct, state enum
// and the modulo helper used by the round-robin logic.
package axi4_write_arbiter_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int AW_INFO_W     = 16 + ADDRESS_WIDTH + 8 + 3 + 2;

  typedef struct packed {
    logic [15:0]              awid;
    logic [ADDRESS_WIDTH-1:0] awaddr;
    logic [7:0]               awlen;
    logic [2:0]               awsize;
    logic [1:0]               awburst;
  } axi4_aw_info_s;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_AW   = 2'd1,
    ARB_W    = 2'd2
  } arb_state_e;

  // Reduce a value in [0, 2n) into [0, n).
  function automatic int rr_wrap(input int value, input int n);
    return (value >= n) ? (value - n) : value;
  endfunction

endpackage

// File: rtl/axi4_write_arbiter_if.sv
// Bundle of the per-master AW/W ports and the single shared slave AW/W port.
// The arbiter is the bus master of the shared slave port; the environment is the slave side.
interface axi4_write_arbiter_if #(
  parameter int NO_OF_MASTERS = 4,
  parameter int DATA_WIDTH    = 32
) ();
  import axi4_write_arbiter_pkg::*;

  logic [NO_OF_MASTERS-1:0]                   m_awvalid;
  axi4_aw_info_s [NO_OF_MASTERS-1:0]          m_awinfo;
  logic [NO_OF_MASTERS-1:0]                   m_awready;
  logic [NO_OF_MASTERS-1:0]                   m_wvalid;
  logic [NO_OF_MASTERS-1:0][DATA_WIDTH-1:0]   m_wdata;
  logic [NO_OF_MASTERS-1:0][DATA_WIDTH/8-1:0] m_wstrb;
  logic [NO_OF_MASTERS-1:0]                   m_wlast;
  logic [NO_OF_MASTERS-1:0]                   m_wready;

  logic                    s_awvalid;
  axi4_aw_info_s           s_awinfo;
  logic                    s_awready;
  logic                    s_wvalid;
  logic [DATA_WIDTH-1:0]   s_wdata;
  logic [DATA_WIDTH/8-1:0] s_wstrb;
  logic                    s_wlast;
  logic                    s_wready;

  modport master (
    input  m_awvalid, m_awinfo, m_wvalid, m_wdata, m_wstrb, m_wlast, s_awready, s_wready,
    output m_awready, m_wready, s_awvalid, s_awinfo, s_wvalid, s_wdata, s_wstrb, s_wlast
  );

  modport slave (
    output m_awvalid, m_awinfo, m_wvalid, m_wdata, m_wstrb, m_wlast, s_awready, s_wready,
    input  m_awready, m_wready, s_awvalid, s_awinfo, s_wvalid, s_wdata, s_wstrb, s_wlast
  );

endinterface

// File: rtl/axi4_rr_arbiter.sv
// Combinational N-way round-robin pick: first asserted request at or after i_ptr, modulo N.
module axi4_rr_arbiter
  import axi4_write_arbiter_pkg::*;
#(
  parameter int NO_OF_MASTERS = 4
) (
  input  logic [NO_OF_MASTERS-1:0]         i_req,
  input  logic [$clog2(NO_OF_MASTERS)-1:0] i_ptr,
  output logic                             o_found,
  output logic [$clog2(NO_OF_MASTERS)-1:0] o_idx
);

  localparam int IDX_W = $clog2(NO_OF_MASTERS);

  logic [IDX_W-1:0] w_cand;

  // Scan from the farthest offset down so the nearest requester to i_ptr wins last.
  always_comb begin
    o_found = |i_req;
    o_idx   = '0;
    w_cand  = '0;
    for (int i = NO_OF_MASTERS - 1; i >= 0; i--) begin
      w_cand = IDX_W'(rr_wrap(int'(i_ptr) + i, NO_OF_MASTERS));
      o_idx  = i_req[w_cand] ? w_cand : o_idx;
    end
  end

endmodule

// File: rtl/axi4_write_arbiter.sv
// Round-robin arbiter sharing one AXI4 slave write port (AW + W) between several masters;
// routes awlen+1 W beats per grant and generates wlast from its own beat counter.
module axi4_write_arbiter
  import axi4_write_arbiter_pkg::*;
#(
  parameter int NO_OF_MASTERS = 4,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                             aclk,
  input  logic                             areset,
  axi4_write_arbiter_if.master             bus,
  output logic [$clog2(NO_OF_MASTERS)-1:0] grant_id,
  output logic                             busy,
  output logic                             wlast_err
);

  localparam int IDX_W = $clog2(NO_OF_MASTERS);

  arb_state_e       r_state;
  arb_state_e       w_next_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_grant_id;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_found;
  axi4_aw_info_s    r_awinfo;
  logic [7:0]       r_beat_cnt;
  logic [7:0]       r_len;
  logic             r_wlast_err;
  logic             w_s_wvalid;
  logic             w_s_wlast;
  logic             w_beat;

  axi4_rr_arbiter #(
    .NO_OF_MASTERS (NO_OF_MASTERS)
  ) u_rr_arbiter (
    .i_req   (bus.m_awvalid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  assign w_s_wvalid = (r_state == ARB_W) && bus.m_wvalid[r_grant_id];
  assign w_s_wlast  = (r_beat_cnt == r_len);
  assign w_beat     = w_s_wvalid && bus.s_wready;

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; arbitration only ever starts from IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_pick_found) w_next_state = ARB_AW;
        else              w_next_state = ARB_IDLE;
      end
      ARB_AW: begin
        if (bus.s_awready) w_next_state = ARB_W;
        else               w_next_state = ARB_AW;
      end
      ARB_W: begin
        if (w_beat && w_s_wlast) w_next_state = ARB_IDLE;
        else                     w_next_state = ARB_W;
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

  // Grant, payload, beat counter, priority pointer and wlast-mismatch pulse.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_awinfo    <= '0;
      r_beat_cnt  <= 8'd0;
      r_len       <= 8'd0;
      r_wlast_err <= 1'b0;
    end else begin
      r_wlast_err <= w_beat && (bus.m_wlast[r_grant_id] != w_s_wlast);
      case (r_state)
        ARB_IDLE: begin
          if (w_pick_found) begin
            r_grant_id <= w_pick_idx;
            r_awinfo   <= bus.m_awinfo[w_pick_idx];
            r_beat_cnt <= 8'd0;
          end
        end
        ARB_AW: begin
          if (bus.s_awready) r_len <= r_awinfo.awlen;
        end
        ARB_W: begin
          // The counter stops at len: the final beat rewinds it and rotates priority.
          if (w_beat) begin
            if (w_s_wlast) begin
              r_beat_cnt <= 8'd0;
              r_rr_ptr   <= IDX_W'(rr_wrap(int'(r_grant_id) + 1, NO_OF_MASTERS));
            end else begin
              r_beat_cnt <= r_beat_cnt + 8'd1;
            end
          end
        end
        default: r_beat_cnt <= 8'd0;
      endcase
    end
  end

  // Bus outputs decoded from the registered state; only the owner is ever connected.
  always_comb begin
    bus.m_awready = '0;
    bus.m_wready  = '0;
    bus.s_awvalid = 1'b0;
    bus.s_awinfo  = '0;
    bus.s_wvalid  = 1'b0;
    bus.s_wdata   = '0;
    bus.s_wstrb   = '0;
    bus.s_wlast   = 1'b0;
    case (r_state)
      ARB_AW: begin
        bus.s_awvalid             = 1'b1;
        bus.s_awinfo              = r_awinfo;
        bus.m_awready[r_grant_id] = bus.s_awready;
      end
      ARB_W: begin
        bus.s_wvalid             = w_s_wvalid;
        bus.s_wdata              = bus.m_wdata[r_grant_id];
        bus.s_wstrb              = bus.m_wstrb[r_grant_id];
        bus.s_wlast              = w_s_wlast;
        bus.m_wready[r_grant_id] = bus.s_wready;
      end
      default: bus.s_awvalid = 1'b0;
    endcase
  end

  assign grant_id  = r_grant_id;
  assign busy      = (r_state != ARB_IDLE);
  assign wlast_err = r_wlast_err;

endmodule

// File: tb/tb_axi4_write_arbiter.sv
// Randomized bench for axi4_write_arbiter: TB masters/slave drive traffic and a
// transaction-level reference model predicts every output each cycle.
module tb_axi4_write_arbiter;
  import axi4_write_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;

  logic         aclk = 1'b0;
  logic         areset;
  logic [1:0]   grant_id;
  logic         busy;
  logic         wlast_err;

  axi4_write_arbiter_if #(.NO_OF_MASTERS(N), .DATA_WIDTH(DW)) bus ();

  axi4_write_arbiter #(.NO_OF_MASTERS(N), .DATA_WIDTH(DW)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .bus       (bus),
    .grant_id  (grant_id),
    .busy      (busy),
    .wlast_err (wlast_err)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  // stimulus configuration
  logic [N-1:0] cfg_en;
  int cfg_txns, cfg_len_min, cfg_len_max, cfg_req_pct, cfg_wv_pct;
  int cfg_aw_delay, cfg_wr_mode, cfg_early_w, cfg_err_pct, cfg_err_master, cfg_err_beat;

  // TB master / slave agents
  bit            aw_pend[N];
  bit            w_act[N];
  bit            d_wv[N];
  axi4_aw_info_s d_info[N];
  int            d_sent[N];
  int            d_inj[N];
  int            txn_left[N];
  logic [31:0]   d_data[N];
  logic [3:0]    d_strb[N];
  int            aw_wait, aw_delay;
  bit            wr_tog;

  // reference model: 0 = free (arbitrating), 1 = address phase, 2 = data phase
  int            ph, rr, own, beat, len;
  bit            exp_err;
  axi4_aw_info_s own_info;
  int            tot_beats, tot_exp;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] req);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic new_aw_delay();
    aw_delay = (cfg_aw_delay >= 0) ? cfg_aw_delay : int'($urandom_range(3, 0));
  endtask

  task automatic clear_all();
    for (int m = 0; m < N; m++) begin
      aw_pend[m] = 1'b0; w_act[m] = 1'b0; d_wv[m] = 1'b0; d_info[m] = '0;
      d_sent[m] = 0; d_inj[m] = -1; txn_left[m] = 0; d_data[m] = '0; d_strb[m] = '0;
    end
    bus.m_awvalid = '0; bus.m_awinfo = '0; bus.m_wvalid = '0; bus.m_wdata = '0;
    bus.m_wstrb = '0; bus.m_wlast = '0; bus.s_awready = 1'b0; bus.s_wready = 1'b0;
    aw_wait = 0; wr_tog = 1'b0;
    ph = 0; rr = 0; own = 0; beat = 0; len = 0; exp_err = 1'b0; own_info = '0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    clear_all();
    repeat (2) @(negedge aclk);
    areset = 1'b0;
  endtask

  task automatic set_cfg(input logic [N-1:0] en, input int txns, input int lmin, input int lmax,
                         input int req, input int wv, input int awd, input int wrm,
                         input int early, input int errp, input int errm, input int errb);
    cfg_en = en; cfg_txns = txns; cfg_len_min = lmin; cfg_len_max = lmax; cfg_req_pct = req;
    cfg_wv_pct = wv; cfg_aw_delay = awd; cfg_wr_mode = wrm; cfg_early_w = early;
    cfg_err_pct = errp; cfg_err_master = errm; cfg_err_beat = errb;
    for (int m = 0; m < N; m++) txn_left[m] = en[m] ? txns : 0;
    tot_beats = 0; tot_exp = 0;
    new_aw_delay();
  endtask

  task automatic drive();
    for (int m = 0; m < N; m++) begin
      if (!aw_pend[m] && !w_act[m] && cfg_en[m] && txn_left[m] > 0 &&
          int'($urandom_range(99, 0)) < cfg_req_pct) begin
        d_info[m].awid    = 16'($urandom);
        d_info[m].awaddr  = $urandom;
        d_info[m].awlen   = 8'($urandom_range(cfg_len_max, cfg_len_min));
        d_info[m].awsize  = 3'd2;
        d_info[m].awburst = 2'd1;
        d_sent[m] = 0;
        if (m == cfg_err_master) d_inj[m] = cfg_err_beat;
        else if (int'($urandom_range(99, 0)) < cfg_err_pct)
          d_inj[m] = int'($urandom_range(int'(d_info[m].awlen), 0));
        else d_inj[m] = -1;
        d_data[m] = $urandom;
        d_strb[m] = 4'($urandom);
        aw_pend[m] = 1'b1;
        txn_left[m]--;
      end
      if (!d_wv[m])
        d_wv[m] = (w_act[m] || (aw_pend[m] && cfg_early_w != 0)) &&
                  (int'($urandom_range(99, 0)) < cfg_wv_pct);
      bus.m_awvalid[m] = aw_pend[m];
      bus.m_awinfo[m]  = d_info[m];
      bus.m_wvalid[m]  = d_wv[m];
      bus.m_wdata[m]   = d_data[m];
      bus.m_wstrb[m]   = d_strb[m];
      bus.m_wlast[m]   = (d_sent[m] == int'(d_info[m].awlen)) ^ (d_sent[m] == d_inj[m]);
    end
    bus.s_awready = (aw_wait >= aw_delay);
    case (cfg_wr_mode)
      0: bus.s_wready = 1'b1;
      1: begin wr_tog = !wr_tog; bus.s_wready = wr_tog; end
      default: bus.s_wready = 1'($urandom_range(1, 0));
    endcase
  endtask

  task automatic check_and_update();
    logic [N-1:0] exp_v;
    bit           exp_wv;
    check_eq("s_awvalid", 64'(bus.s_awvalid), 64'(ph == 1));
    check_eq("busy", 64'(busy), 64'(ph != 0));
    if (ph != 0) check_eq("grant_id", 64'(grant_id), 64'(own));
    if (ph == 1) check_eq("s_awinfo", 64'(bus.s_awinfo), 64'(own_info));
    exp_v = '0;
    if (ph == 1 && bus.s_awready) exp_v[own] = 1'b1;
    check_eq("m_awready", 64'(bus.m_awready), 64'(exp_v));
    exp_v = '0;
    if (ph == 2 && bus.s_wready) exp_v[own] = 1'b1;
    check_eq("m_wready", 64'(bus.m_wready), 64'(exp_v));
    exp_wv = (ph == 2) && bus.m_wvalid[own];
    check_eq("s_wvalid", 64'(bus.s_wvalid), 64'(exp_wv));
    if (exp_wv) begin
      check_eq("s_wdata", 64'(bus.s_wdata), 64'(bus.m_wdata[own]));
      check_eq("s_wstrb", 64'(bus.s_wstrb), 64'(bus.m_wstrb[own]));
      check_eq("s_wlast", 64'(bus.s_wlast), 64'(beat == len));
    end
    check_eq("wlast_err", 64'(wlast_err), 64'(exp_err));

    exp_err = 1'b0;
    case (ph)
      0: if (|bus.m_awvalid) begin
        own = rr_pick(rr, bus.m_awvalid);
        own_info = bus.m_awinfo[own];
        ph = 1;
      end
      1: if (bus.s_awready) begin
        ph = 2; beat = 0; len = int'(own_info.awlen); tot_exp += len + 1;
      end
      default: if (bus.m_wvalid[own] && bus.s_wready) begin
        exp_err = bus.m_wlast[own] != (beat == len);
        tot_beats++;
        if (beat == len) begin ph = 0; rr = (own + 1) % N; end
        else beat++;
      end
    endcase

    for (int m = 0; m < N; m++) begin
      if (bus.m_awvalid[m] && bus.m_awready[m]) begin
        aw_pend[m] = 1'b0; w_act[m] = 1'b1;
      end
      if (bus.m_wvalid[m] && bus.m_wready[m]) begin
        d_sent[m]++; d_wv[m] = 1'b0; d_data[m] = $urandom; d_strb[m] = 4'($urandom);
        if (d_sent[m] > int'(d_info[m].awlen)) w_act[m] = 1'b0;
      end
    end
    if (bus.s_awvalid && bus.s_awready) begin aw_wait = 0; new_aw_delay(); end
    else if (bus.s_awvalid) aw_wait++;
  endtask

  task automatic step();
    @(negedge aclk);
    drive();
    #1;
    check_and_update();
  endtask

  function automatic bit all_done();
    for (int m = 0; m < N; m++) begin
      if (txn_left[m] > 0 || aw_pend[m] || w_act[m]) return 1'b0;
    end
    return ph == 0;
  endfunction

  task automatic drain(input string tag, input int budget);
    int cyc = 0;
    while (!all_done() && cyc < budget) begin step(); cyc++; end
    if (cyc >= budget) check_eq({tag, "_timeout"}, 64'(cyc), 64'(0));
    repeat (3) step();
    check_eq({tag, "_beats"}, 64'(tot_beats), 64'(tot_exp));
  endtask

  initial begin
    areset = 1'b1;
    clear_all();
    #1;
    check_eq("rst_s_awvalid", 64'(bus.s_awvalid), 64'(0));
    check_eq("rst_s_awinfo", 64'(bus.s_awinfo), 64'(0));
    check_eq("rst_busy_grant", 64'({busy, grant_id, wlast_err}), 64'(0));
    check_eq("rst_readies", 64'({bus.m_awready, bus.m_wready}), 64'(0));
    do_reset();

    // single master 2, awlen=3, then masters 0 and 3 together (priority now at 3)
    set_cfg(4'b0100, 1, 3, 3, 100, 100, 0, 0, 0, 0, -1, -1);
    drain("single", 200);
    check_eq("single_nbeats", 64'(tot_beats), 64'(4));
    set_cfg(4'b1001, 1, 0, 2, 100, 100, 0, 0, 0, 0, -1, -1);
    drain("rr_after", 200);

    do_reset();
    set_cfg(4'b1111, 2, 0, 0, 100, 100, 0, 0, 0, 0, -1, -1);
    drain("all4", 200);
    check_eq("all4_nbeats", 64'(tot_beats), 64'(8));

    do_reset();
    set_cfg(4'b0001, 1, 7, 7, 100, 100, 5, 1, 0, 0, -1, -1);
    drain("backpr", 200);
    check_eq("backpr_nbeats", 64'(tot_beats), 64'(8));

    do_reset();
    set_cfg(4'b0010, 1, 3, 3, 100, 100, 0, 0, 0, 0, 1, 1);
    drain("wlasterr", 200);

    do_reset();
    set_cfg(4'b0001, 1, 255, 255, 100, 100, 0, 0, 0, 0, -1, -1);
    drain("len255", 600);
    check_eq("len255_nbeats", 64'(tot_beats), 64'(256));

    // reset in the middle of a burst, then master 3 must be served normally
    do_reset();
    set_cfg(4'b0010, 1, 7, 7, 100, 100, 0, 0, 0, 0, -1, -1);
    begin
      int cyc = 0;
      while (!(ph == 2 && beat == 2) && cyc < 100) begin step(); cyc++; end
      if (cyc >= 100) check_eq("midrst_timeout", 64'(cyc), 64'(0));
    end
    areset = 1'b1;
    #1;
    check_eq("midrst_valids", 64'({bus.s_awvalid, bus.s_wvalid, bus.s_wlast}), 64'(0));
    check_eq("midrst_data", 64'({bus.s_wdata, bus.s_wstrb}), 64'(0));
    check_eq("midrst_readies", 64'({bus.m_awready, bus.m_wready}), 64'(0));
    check_eq("midrst_status", 64'({busy, grant_id, wlast_err}), 64'(0));
    clear_all();
    @(negedge aclk);
    areset = 1'b0;
    set_cfg(4'b1000, 1, 2, 2, 100, 100, 0, 0, 0, 0, -1, -1);
    drain("midrst_m3", 200);

    do_reset();
    set_cfg(4'b1111, 40, 0, 15, 60, 70, -1, 2, 1, 30, -1, -1);
    drain("random", 20000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
